// File: rtl/shift_in_chain_pkg.sv
// ---------------------------------------------------------------------------
// shift_in_chain_pkg
//   Shared types and constants for the 74HC165 shift-in chain reader.
//
//   shiftin_state_t : frame sequencer states.
//                     LOAD -> SHIFT_LO -> SHIFT_HI -> ... -> DONE
//   DEB_CNT_W       : width of every per-bit debounce counter and of the
//                     frame counter that drives 'valid'. Sized for a
//                     filter depth of up to 4 frames (counts 0..3).
// ---------------------------------------------------------------------------
package shift_in_chain_pkg;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    DONE     = 2'd3
  } shiftin_state_t;

  localparam int DEB_CNT_W = 2;

  // Counter value at which a run of DEBOUNCE frames is complete. A run
  // counter that already holds DEBOUNCE-1 previous frames completes the
  // run on the current one.
  function automatic logic [DEB_CNT_W-1:0] debLimit(input int depth);
    return DEB_CNT_W'(depth - 1);
  endfunction

endpackage

// File: rtl/shift_in_chain_debounce.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   Single-bit frame-based debounce cell. One instance per chain input.
//   The filtered output only follows the raw bit after DEBOUNCE
//   consecutive frames that all disagree with the current output. With
//   DEBOUNCE=1 the output simply follows the raw bit every update.
//
// Ports
//   clk28         in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   i_update      in   one-cycle strobe, a complete frame is in i_raw
//   i_raw         in   freshly sampled bit of the current frame
//   o_d           out  filtered bit (registered)
//   o_willChange  out  high in the update cycle when o_d is about to flip
// ---------------------------------------------------------------------------
module debounce_bit
  import shift_in_chain_pkg::*;
#(
  parameter int   DEBOUNCE      = 1,
  parameter logic DEFAULT_STATE = 1'b1
) (
  input  logic clk28,
  input  logic rst,
  input  logic i_update,
  input  logic i_raw,
  output logic o_d,
  output logic o_willChange
);

  localparam logic [DEB_CNT_W-1:0] LIMIT = debLimit(DEBOUNCE);

  logic                 r_d;
  logic [DEB_CNT_W-1:0] r_count;
  logic                 w_differs;
  logic                 w_atLimit;

  // The counter holds how many earlier frames in a row disagreed with
  // the output, so the current disagreeing frame completes the run when
  // the counter already sits at DEBOUNCE-1.
  assign w_differs    = (i_raw != r_d);
  assign w_atLimit    = (r_count == LIMIT);
  assign o_willChange = i_update && w_differs && w_atLimit;
  assign o_d          = r_d;

  // Filter state: any agreeing frame restarts the run; a completed run
  // takes the raw value and restarts the counter for the next change.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_d     <= DEFAULT_STATE;
      r_count <= '0;
    end else if (i_update) begin
      if (!w_differs) begin
        r_count <= '0;
      end else if (w_atLimit) begin
        r_d     <= i_raw;
        r_count <= '0;
      end else begin
        r_count <= r_count + DEB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/shift_in_chain.sv
// ---------------------------------------------------------------------------
// shift_in_chain
//   Reads a chain of 74HC165 parallel-in/serial-out shift registers and
//   presents the inputs as a debounced parallel word.
//
//   One frame is 2*WIDTH+2 enabled steps:
//     LOAD      pl low, the chain latches its parallel inputs
//     SHIFT_LO  cp low, Q7 of the chain is sampled into the raw word
//     SHIFT_HI  cp high, the chain moves the next bit onto Q7
//     DONE      raw word is handed to the debounce cells, sync pulses
//
// Parameters
//   WIDTH          chain length in bits, multiple of 8, 8..32
//   DEFAULT_STATE  value of every d bit (and raw bit) after reset
//   INVERT         1 inverts each sampled bit before debouncing
//   DEBOUNCE       frames of agreement needed to change a d bit, 1..4
//
// Ports
//   clk28    in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   clk_en   in   step enable; the sequencer only moves when high
//   q        in   serial data from the last chain stage (Q7)
//   cp       out  chain shift clock (registered)
//   pl       out  chain parallel load, active low (registered)
//   d        out  debounced parallel word
//   sync     out  one clk28 pulse after each completed frame
//   changed  out  one clk28 pulse with sync when d took a new value
//   valid    out  set once DEBOUNCE frames have completed since reset
// ---------------------------------------------------------------------------
module shift_in_chain
  import shift_in_chain_pkg::*;
#(
  parameter int   WIDTH         = 8,
  parameter logic DEFAULT_STATE = 1'b1,
  parameter bit   INVERT        = 1'b0,
  parameter int   DEBOUNCE      = 1
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             q,
  output logic             cp,
  output logic             pl,
  output logic [WIDTH-1:0] d,
  output logic             sync,
  output logic             changed,
  output logic             valid
);

  localparam int                    CNT_W       = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]      LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic [DEB_CNT_W-1:0]  VALID_LIMIT = debLimit(DEBOUNCE);

  shiftin_state_t         r_state;
  shiftin_state_t         w_nextState;
  logic [CNT_W-1:0]       r_bitCount;
  logic [CNT_W-1:0]       w_nextBitCount;
  logic                   r_cp;
  logic                   r_pl;
  logic                   w_nextCp;
  logic                   w_nextPl;
  logic [WIDTH-1:0]       r_raw;
  logic                   w_sample;
  logic                   w_update;
  logic [WIDTH-1:0]       w_changeBits;
  logic                   r_sync;
  logic                   r_changed;
  logic                   r_valid;
  logic [DEB_CNT_W-1:0]   r_frameCount;

  assign w_sample = q ^ INVERT;
  assign w_update = clk_en && (r_state == DONE);

  assign cp      = r_cp;
  assign pl      = r_pl;
  assign sync    = r_sync;
  assign changed = r_changed;
  assign valid   = r_valid;

  // Sequencer state register. cp and pl are registered together with the
  // state they belong to, so the chain sees clean edges and pl can never
  // be low while cp is high.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_state    <= LOAD;
      r_bitCount <= '0;
      r_cp       <= 1'b0;
      r_pl       <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_bitCount <= w_nextBitCount;
      r_cp       <= w_nextCp;
      r_pl       <= w_nextPl;
    end
  end

  // Next-state logic. Without clk_en everything holds, including the
  // chain control lines. The chain outputs are decoded from the state
  // being entered so that they are valid for the whole of that state.
  always_comb begin
    w_nextState    = r_state;
    w_nextBitCount = r_bitCount;
    w_nextCp       = r_cp;
    w_nextPl       = r_pl;

    if (clk_en) begin
      case (r_state)
        LOAD: begin
          w_nextState    = SHIFT_LO;
          w_nextBitCount = '0;
        end
        SHIFT_LO: begin
          w_nextState = SHIFT_HI;
        end
        SHIFT_HI: begin
          if (r_bitCount < LAST_BIT) begin
            w_nextState    = SHIFT_LO;
            w_nextBitCount = r_bitCount + CNT_W'(1);
          end else begin
            w_nextState = DONE;
          end
        end
        DONE: begin
          w_nextState = LOAD;
        end
        default: begin
          w_nextState    = LOAD;
          w_nextBitCount = '0;
        end
      endcase

      case (w_nextState)
        LOAD:     begin w_nextPl = 1'b0; w_nextCp = 1'b0; end
        SHIFT_LO: begin w_nextPl = 1'b1; w_nextCp = 1'b0; end
        SHIFT_HI: begin w_nextPl = 1'b1; w_nextCp = 1'b1; end
        default:  begin w_nextPl = 1'b1; w_nextCp = 1'b0; end
      endcase
    end
  end

  // Raw frame capture and the frame-complete strobes. Bits arrive MSB
  // first, so shifting left leaves the first sampled bit at the top.
  // sync/changed are plain registers of the DONE step, so they are
  // exactly one clk28 wide and stay low whenever clk_en is low.
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_raw        <= {WIDTH{DEFAULT_STATE}};
      r_sync       <= 1'b0;
      r_changed    <= 1'b0;
      r_valid      <= 1'b0;
      r_frameCount <= '0;
    end else begin
      if (clk_en && (r_state == SHIFT_LO)) begin
        r_raw <= {r_raw[WIDTH-2:0], w_sample};
      end
      r_sync    <= w_update;
      r_changed <= w_update && (|w_changeBits);
      if (w_update && !r_valid) begin
        if (r_frameCount == VALID_LIMIT) begin
          r_valid <= 1'b1;
        end else begin
          r_frameCount <= r_frameCount + DEB_CNT_W'(1);
        end
      end
    end
  end

  // One filter cell per chain input. All cells update on the same DONE
  // step, which keeps the d word coherent.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
    debounce_bit #(
      .DEBOUNCE      (DEBOUNCE),
      .DEFAULT_STATE (DEFAULT_STATE)
    ) u_debounceBit (
      .clk28        (clk28),
      .rst          (rst),
      .i_update     (w_update),
      .i_raw        (r_raw[gi]),
      .o_d          (d[gi]),
      .o_willChange (w_changeBits[gi])
    );
  end

endmodule

// File: tb/tb_shift_in_chain.sv
// Testbench for shift_in_chain. Four instances share clock, reset and
// step enable: a plain 8-bit reader, an inverting 8-bit reader, a
// 3-frame debounced 8-bit reader and a 16-bit reader. Each has its own
// 74HC165 chain model feeding q from a bench-chosen parallel word.
module tb_shift_in_chain;

  localparam int DEB = 3;

  logic clk28 = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;

  int checks = 0;
  int failures = 0;
  int stepCount = 0;
  int enMode = 1;
  bit stall = 1'b0;
  int phase = 0;

  logic qA, cpA, plA, syncA, chA, vA;
  logic [7:0] dA;
  logic qI, cpI, plI, syncI, chI, vI;
  logic [7:0] dI;
  logic qD, cpD, plD, syncD, chD, vD;
  logic [7:0] dD;
  logic qW, cpW, plW, syncW, chW, vW;
  logic [15:0] dW;

  logic [7:0] parA = 8'hA5, parI = 8'h0F, parD = 8'hFF;
  logic [15:0] parW = 16'h1234;
  logic [7:0] chainA, chainI, chainD;
  logic [15:0] chainW;
  logic prevCpA, prevCpI, prevCpD, prevCpW;

  logic [7:0] prevA, prevI, refD;
  logic [7:0] histD[$];
  int framesDone;

  logic [15:0] expW = 16'h1234;
  int lastSyncStepW = 0;
  bit haveW = 1'b0;
  int wSyncs = 0;

  always #5 clk28 = ~clk28;

  shift_in_chain #(.WIDTH(8), .DEFAULT_STATE(1'b1), .INVERT(1'b0), .DEBOUNCE(1)) dutA (
    .clk28(clk28), .rst(rst), .clk_en(clk_en), .q(qA), .cp(cpA), .pl(plA),
    .d(dA), .sync(syncA), .changed(chA), .valid(vA));
  shift_in_chain #(.WIDTH(8), .DEFAULT_STATE(1'b1), .INVERT(1'b1), .DEBOUNCE(1)) dutI (
    .clk28(clk28), .rst(rst), .clk_en(clk_en), .q(qI), .cp(cpI), .pl(plI),
    .d(dI), .sync(syncI), .changed(chI), .valid(vI));
  shift_in_chain #(.WIDTH(8), .DEFAULT_STATE(1'b1), .INVERT(1'b0), .DEBOUNCE(DEB)) dutD (
    .clk28(clk28), .rst(rst), .clk_en(clk_en), .q(qD), .cp(cpD), .pl(plD),
    .d(dD), .sync(syncD), .changed(chD), .valid(vD));
  shift_in_chain #(.WIDTH(16), .DEFAULT_STATE(1'b1), .INVERT(1'b0), .DEBOUNCE(1)) dutW (
    .clk28(clk28), .rst(rst), .clk_en(clk_en), .q(qW), .cp(cpW), .pl(plW),
    .d(dW), .sync(syncW), .changed(chW), .valid(vW));

  // 74HC165 chain models: parallel load while pl is low, shift toward Q7
  // on each rising cp, Q7 is the top bit.
  assign qA = chainA[7];
  assign qI = chainI[7];
  assign qD = chainD[7];
  assign qW = chainW[15];

  always @(posedge clk28) begin
    if (!plA) chainA <= parA; else if (cpA && !prevCpA) chainA <= {chainA[6:0], 1'b0};
    if (!plI) chainI <= parI; else if (cpI && !prevCpI) chainI <= {chainI[6:0], 1'b0};
    if (!plD) chainD <= parD; else if (cpD && !prevCpD) chainD <= {chainD[6:0], 1'b0};
    if (!plW) chainW <= parW; else if (cpW && !prevCpW) chainW <= {chainW[14:0], 1'b0};
    prevCpA <= cpA; prevCpI <= cpI; prevCpD <= cpD; prevCpW <= cpW;
  end

  // Counts enabled steps as the design sees them.
  always @(posedge clk28) begin
    if (clk_en) stepCount <= stepCount + 1;
  end

  // Step-enable generator: every cycle, every 4th cycle, or random.
  initial begin
    forever begin
      @(posedge clk28);
      #2;
      phase = phase + 1;
      case (enMode)
        0:       clk_en = !stall;
        1:       clk_en = !stall && (phase % 4 == 0);
        default: clk_en = !stall && ($urandom_range(1, 0) == 1);
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference debounce: a bit flips once the last DEB frames all
  // disagreed with its current value.
  function automatic logic [7:0] debounceModel(input logic [7:0] raw);
    logic [7:0] res;
    res = refD;
    histD.push_back(raw);
    if (histD.size() > DEB) void'(histD.pop_front());
    if (histD.size() == DEB) begin
      for (int b = 0; b < 8; b++) begin
        bit allOpposite;
        allOpposite = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (histD[k][b] == refD[b]) allOpposite = 1'b0;
        end
        if (allOpposite) res[b] = ~refD[b];
      end
    end
    return res;
  endfunction

  task automatic resetModel();
    prevA = 8'hFF;
    prevI = 8'hFF;
    refD = 8'hFF;
    histD.delete();
    framesDone = 0;
  endtask

  // 16-bit reader is checked frame by frame on its own sync pulses.
  always @(negedge clk28) begin
    if (rst) begin
      haveW = 1'b0;
    end else if (syncW) begin
      checkOutput("w16_d", 32'(dW), 32'(expW));
      if (haveW) checkOutput("w16_period", 32'(stepCount - lastSyncStepW), 32'd34);
      haveW = 1'b1;
      wSyncs++;
      lastSyncStepW = stepCount;
      parW = 16'($urandom);
      expW = parW;
    end
  end

  // Runs one 8-bit frame: presents new chain words while the readers
  // sit in LOAD, optionally stalls clk_en mid-frame, then checks the
  // frame length and every reader's outputs at sync.
  task automatic applyStimulus(input logic [7:0] pa, input logic [7:0] pi,
                               input logic [7:0] pd, input int stallAfter);
    int start, waited;
    bit seen, stalled, moved, syncInStall;
    logic sCp, sPl;
    logic [7:0] newA, newI, newD;
    parA = pa;
    parI = pi;
    parD = pd;
    start = stepCount;
    seen = 1'b0;
    stalled = 1'b0;
    waited = 0;
    checkOutput("frame_start_pl", 32'(plA), 32'd0);
    while (!seen && waited < 2000) begin
      @(negedge clk28);
      waited++;
      if (waited == 1) checkOutput("sync_pulse_width", 32'(syncA), 32'd0);
      if (stepCount - start == 1 && waited < 2000 && !stalled && plA !== 1'b1)
        checkOutput("first_step_pl", 32'(plA), 32'd1);
      if (stallAfter >= 0 && !stalled && stepCount - start == stallAfter) begin
        stalled = 1'b1;
        stall = 1'b1;
        @(negedge clk28);
        @(negedge clk28);
        sCp = cpA;
        sPl = plA;
        moved = 1'b0;
        syncInStall = 1'b0;
        repeat (100) begin
          @(negedge clk28);
          if (syncA || chA) syncInStall = 1'b1;
          if (cpA !== sCp || plA !== sPl) moved = 1'b1;
        end
        checkOutput("stall_cp_pl_frozen", 32'(moved), 32'd0);
        checkOutput("stall_no_sync", 32'(syncInStall), 32'd0);
        stall = 1'b0;
      end
      if (syncA) seen = 1'b1;
    end
    checkOutput("sync_timeout", 32'(seen), 32'd1);
    if (seen) begin
      framesDone++;
      newA = pa;
      newI = ~pi;
      newD = debounceModel(pd);
      checkOutput("frame_steps", 32'(stepCount - start), 32'd18);
      checkOutput("a_d", 32'(dA), 32'(newA));
      checkOutput("a_changed", 32'(chA), 32'(newA != prevA));
      checkOutput("a_valid", 32'(vA), 32'(framesDone >= 1));
      checkOutput("i_sync", 32'(syncI), 32'd1);
      checkOutput("i_d", 32'(dI), 32'(newI));
      checkOutput("i_changed", 32'(chI), 32'(newI != prevI));
      checkOutput("d_sync", 32'(syncD), 32'd1);
      checkOutput("d_d", 32'(dD), 32'(newD));
      checkOutput("d_changed", 32'(chD), 32'(newD != refD));
      checkOutput("d_valid", 32'(vD), 32'(framesDone >= DEB));
      prevA = newA;
      prevI = newI;
      refD = newD;
    end
  endtask

  initial begin
    int start, waited;
    resetModel();
    rst = 1'b1;
    enMode = 1;
    repeat (6) @(negedge clk28);

    checkOutput("rst_cp", 32'(cpA), 32'd0);
    checkOutput("rst_pl", 32'(plA), 32'd0);
    checkOutput("rst_sync", 32'(syncA), 32'd0);
    checkOutput("rst_changed", 32'(chA), 32'd0);
    checkOutput("rst_valid", 32'(vA), 32'd0);
    checkOutput("rst_d_a", 32'(dA), 32'hFF);
    checkOutput("rst_d_i", 32'(dI), 32'hFF);
    checkOutput("rst_d_d", 32'(dD), 32'hFF);
    checkOutput("rst_d_w", 32'(dW), 32'hFFFF);
    checkOutput("rst_pl_w", 32'(plW), 32'd0);

    rst = 1'b0;
    applyStimulus(8'hA5, 8'h0F, 8'hFF, -1);
    checkOutput("first_frame_a5", 32'(dA), 32'hA5);
    checkOutput("invert_0f", 32'(dI), 32'hF0);

    // Debounce: two short glitches on bit 0 are rejected, three stick.
    applyStimulus(8'($urandom), 8'($urandom), 8'hFE, -1);
    applyStimulus(8'($urandom), 8'($urandom), 8'hFE, -1);
    applyStimulus(8'($urandom), 8'($urandom), 8'hFF, -1);
    checkOutput("deb_glitch_rejected", 32'(dD), 32'hFF);
    applyStimulus(8'($urandom), 8'($urandom), 8'hFE, -1);
    applyStimulus(8'($urandom), 8'($urandom), 8'hFE, -1);
    applyStimulus(8'($urandom), 8'($urandom), 8'hFE, -1);
    checkOutput("deb_third_frame", 32'(dD), 32'hFE);
    checkOutput("deb_third_changed", 32'(chD), 32'd1);

    enMode = 0;
    for (int n = 0; n < 16; n++)
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), -1);
    applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 9);

    enMode = 2;
    for (int n = 0; n < 10; n++)
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), -1);

    // Reset in the SHIFT_HI of bit 5 (12 steps into the frame).
    enMode = 0;
    start = stepCount;
    waited = 0;
    while (stepCount - start < 12 && waited < 500) begin
      @(negedge clk28);
      waited++;
    end
    checkOutput("pre_reset_cp_high", 32'(cpA), 32'd1);
    rst = 1'b1;
    @(negedge clk28);
    checkOutput("midrst_cp", 32'(cpA), 32'd0);
    checkOutput("midrst_pl", 32'(plA), 32'd0);
    checkOutput("midrst_d", 32'(dA), 32'hFF);
    checkOutput("midrst_dd", 32'(dD), 32'hFF);
    checkOutput("midrst_sync", 32'(syncA), 32'd0);
    checkOutput("midrst_valid", 32'(vA), 32'd0);
    repeat (3) @(negedge clk28);
    resetModel();
    rst = 1'b0;
    for (int n = 0; n < 4; n++)
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), -1);

    checkOutput("w16_sync_seen", 32'(wSyncs >= 3), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_in_chain.md
SHIFT_IN_CHAIN -- requirements
Module: shift_in_chain

Interface
REQ-001 Parameter WIDTH, default 8: total input bits in the 74HC165 chain; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter DEFAULT_STATE, default 1'b1: value driven on d and held in every debounce stage after reset.
REQ-003 Parameter INVERT, default 0: when 1, every sampled q bit is inverted before the debounce stage.
REQ-004 Parameter DEBOUNCE, default 1: consecutive identical frames needed before a d bit changes; range 1..4, where 1 means no filtering.
REQ-005 clk28  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 clk_en  input  1  step enable; the state machine advances only on cycles where clk_en=1.
REQ-008 q  input  1  serial data from the chain's last-stage Q7 output.
REQ-009 cp  output  1  chain shift clock; the chain shifts on its rising edge.
REQ-010 pl  output  1  chain parallel load, active-low.
REQ-011 d  output  WIDTH  debounced parallel input word.
REQ-012 sync  output  1  one-clk28 pulse, asserted when a frame completes.
REQ-013 changed  output  1  one-clk28 pulse, coincident with sync, asserted when d changes on that update.
REQ-014 valid  output  1  asserted once DEBOUNCE frames have completed since reset; held until the next reset.

Function
REQ-015 State machine states: LOAD, SHIFT_LO, SHIFT_HI, DONE; every transition SHALL occur only on a clk_en cycle.
REQ-016 LOAD: pl=0, cp=0; after one step, SHALL go to SHIFT_LO with the bit counter at 0.
REQ-017 SHIFT_LO: pl=1, cp=0; SHALL sample q (INVERT applied) into the raw shift register, MSB-first.
REQ-018 Sampling order: the first sampled bit SHALL end up in raw[WIDTH-1] and the last in raw[0].
REQ-019 SHIFT_LO SHALL go to SHIFT_HI.
REQ-020 SHIFT_HI: cp=1; SHALL go to SHIFT_LO with counter+1 if counter<WIDTH-1, else to DONE.
REQ-021 DONE: pl=1, cp=0; SHALL perform the debounce update, pulse sync for exactly one clk28 cycle, then go to LOAD.
REQ-022 Frame length SHALL be exactly 2*WIDTH+2 clk_en steps; the bit counter SHALL be $clog2(WIDTH) bits and never wrap during a frame.
REQ-023 cp and pl SHALL be registered outputs, glitch-free, and never low/high simultaneously in a way that loads and shifts at once (pl=0 implies cp=0).
REQ-024 Debounce with DEBOUNCE>1, per bit: raw equal to d SHALL clear the bit's counter.
REQ-025 Debounce with DEBOUNCE>1, per bit: raw differing from d SHALL increment the counter; on reaching DEBOUNCE-1 the d bit SHALL take the raw value and the counter SHALL clear.
REQ-026 Debounce with DEBOUNCE=1: d SHALL equal raw at every DONE.
REQ-027 changed SHALL be 1 in DONE iff the new d differs from the old d in at least one bit.
REQ-028 valid SHALL rise in the DONE of frame number DEBOUNCE after reset, and SHALL NOT cause changed to be suppressed.
REQ-029 d SHALL update only in DONE, atomically; no partial word is ever visible.
REQ-030 clk_en held low SHALL freeze state, counter, cp and pl; sync and changed SHALL stay 0.

Reset
REQ-031 rst=1 SHALL force, on the next clk28 edge, regardless of state or clk_en: state=LOAD, counter=0, pl=0, cp=0, sync=0, changed=0, valid=0, d={WIDTH{DEFAULT_STATE}}, raw={WIDTH{DEFAULT_STATE}}, all debounce counters=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL start in LOAD.

Structure
REQ-033 The shared common package SHALL hold the state enum type (shiftin_state_t).
REQ-034 The single-bit debounce cell SHALL be a sub-module, debounce_bit, instantiated WIDTH times via generate.
REQ-035 No other sub-modules.

Verification
REQ-036 Reset check: WIDTH=8, DEBOUNCE=1, clk_en every 4th clk28, chain model loaded with 8'hA5 -> after rst release, pl=0 for 1 step; first sync 18 steps later; d=8'hA5, changed=1, valid=1.
REQ-037 Invert check: INVERT=1 with input 8'h0F -> d=8'hF0.
REQ-038 Width check: WIDTH=16 with input 16'h1234 -> sync period = 34 clk_en steps; d=16'h1234.
REQ-039 Debounce check: DEBOUNCE=3, d settled at 8'hFF.
  - Bit0 low for 2 frames, then high -> d remains 8'hFF and changed=0 throughout.
  - Bit0 low for 3 frames -> d=8'hFE on the 3rd DONE, changed=1.
REQ-040 Mid-frame reset: rst asserted at the SHIFT_HI of bit 5 -> same clk28 edge: cp=0, pl=0, d=8'hFF (DEFAULT_STATE=1); no sync until a full new frame completes.
REQ-041 Stall check: clk_en held 0 for 100 cycles mid-frame -> cp and pl unchanged and no sync; resumes and completes with the correct d.
